// File: rtl/posit_raw_mult_pipe_es3.sv
// Elastic pipelined multiplier for raw (unpacked) ES3 posits; emits the full unrounded product.
// Optional define POSIT_RAW_MULT_ZERO_CANON_EN canonicalises zero operands at stage 0.
`timescale 1ns/1ps
module posit_raw_mult_pipe_es3 #(
  parameter int unsigned SCALE_W = 10,
  parameter int unsigned FRAC_W  = 62,
  parameter int unsigned LATENCY = 4,
  parameter int unsigned TAG_W   = 1,
  localparam int unsigned IN_W   = 1 + SCALE_W + FRAC_W + 2,
  localparam int unsigned PF_W   = 2 * (FRAC_W + 1),
  localparam int unsigned OUT_W  = 1 + (SCALE_W + 1) + PF_W + 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in1,
  input  logic [IN_W-1:0]  in2,
  input  logic             in1_truncated,
  input  logic             in2_truncated,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] result,
  output logic             out_truncated,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);

  localparam int unsigned SE_W = SCALE_W + 1;
  localparam int unsigned PD_W = OUT_W + 1 + TAG_W;

  // Stage valid bits and per-stage load enables
  logic [LATENCY-1:0] v_q;
  logic [LATENCY-1:0] v_d;
  logic [LATENCY-1:0] ld_c;

  // Stage 0: unpacked operands
  logic               a_sgn_q, b_sgn_q;
  logic [SCALE_W-1:0] a_scale_q, b_scale_q;
  logic [FRAC_W-1:0]  a_frac_q, b_frac_q;
  logic               a_inf_q, b_inf_q;
  logic               a_zero_q, b_zero_q;
  logic               trunc0_q;
  logic [TAG_W-1:0]   tag0_q;

  logic               a_sgn_c, b_sgn_c;
  logic [SCALE_W-1:0] a_scale_c, b_scale_c;
  logic [FRAC_W-1:0]  a_frac_c, b_frac_c;
  logic               a_inf_c, b_inf_c;
  logic               a_zero_c, b_zero_c;
  logic               a_trunc_c, b_trunc_c;

  // Stages 1..LATENCY-1: {result, truncated, tag}
  logic [LATENCY-1:1][PD_W-1:0] pd_q;
  logic [LATENCY-1:1][PD_W-1:0] pd_d;

  logic [PF_W-1:0]    mant_c;
  logic [PF_W-1:0]    frac_c;
  logic [SE_W-1:0]    scale_c;
  logic               sgn_c, inf_c, zero_c;
  logic [PD_W-1:0]    prod_c;

  // A stage loads when it or any later stage has room, or the output drains
  for (genvar g = 0; g < LATENCY; g++) begin : g_ld
    assign ld_c[g] = out_ready | ~(&v_q[LATENCY-1:g]);
  end

  assign in_ready = ld_c[0];
  assign v_d[0]   = ld_c[0] ? in_valid : v_q[0];
  for (genvar g = 1; g < LATENCY; g++) begin : g_vd
    assign v_d[g] = ld_c[g] ? v_q[g-1] : v_q[g];
  end

  // Operand unpack, with optional zero canonicalisation
  always_comb begin
    a_sgn_c   = in1[IN_W-1];
    a_scale_c = in1[IN_W-2 -: SCALE_W];
    a_frac_c  = in1[FRAC_W+1:2];
    a_inf_c   = in1[1];
    a_zero_c  = in1[0];
    a_trunc_c = in1_truncated;
    b_sgn_c   = in2[IN_W-1];
    b_scale_c = in2[IN_W-2 -: SCALE_W];
    b_frac_c  = in2[FRAC_W+1:2];
    b_inf_c   = in2[1];
    b_zero_c  = in2[0];
    b_trunc_c = in2_truncated;
`ifdef POSIT_RAW_MULT_ZERO_CANON_EN
    if (a_zero_c) begin
      a_sgn_c   = 1'b0;
      a_scale_c = '0;
      a_frac_c  = '0;
      a_inf_c   = 1'b0;
      a_trunc_c = 1'b0;
    end
    if (b_zero_c) begin
      b_sgn_c   = 1'b0;
      b_scale_c = '0;
      b_frac_c  = '0;
      b_inf_c   = 1'b0;
      b_trunc_c = 1'b0;
    end
`endif
  end

  // Product and normalisation by one position; hidden bit shifted out
  always_comb begin
    mant_c  = PF_W'({1'b1, a_frac_q}) * PF_W'({1'b1, b_frac_q});
    scale_c = {a_scale_q[SCALE_W-1], a_scale_q} + {b_scale_q[SCALE_W-1], b_scale_q}
            + SE_W'(mant_c[PF_W-1]);
    if (mant_c[PF_W-1]) begin
      frac_c = {mant_c[PF_W-2:0], 1'b0};
    end else begin
      frac_c = {mant_c[PF_W-3:0], 2'b00};
    end
    sgn_c  = a_sgn_q ^ b_sgn_q;
    inf_c  = a_inf_q | b_inf_q;
    zero_c = ~inf_c & (a_zero_q | b_zero_q);
    prod_c = {sgn_c, scale_c, frac_c, inf_c, zero_c, trunc0_q, tag0_q};
  end

  assign pd_d[1] = (ld_c[1] && v_q[0]) ? prod_c : pd_q[1];
  for (genvar g = 2; g < LATENCY; g++) begin : g_pd
    assign pd_d[g] = (ld_c[g] && v_q[g-1]) ? pd_q[g-1] : pd_q[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      pd_q      <= '0;
      a_sgn_q   <= 1'b0;
      b_sgn_q   <= 1'b0;
      a_scale_q <= '0;
      b_scale_q <= '0;
      a_frac_q  <= '0;
      b_frac_q  <= '0;
      a_inf_q   <= 1'b0;
      b_inf_q   <= 1'b0;
      a_zero_q  <= 1'b0;
      b_zero_q  <= 1'b0;
      trunc0_q  <= 1'b0;
      tag0_q    <= '0;
    end else begin
      v_q  <= v_d;
      pd_q <= pd_d;
      if (ld_c[0] && in_valid) begin
        a_sgn_q   <= a_sgn_c;
        b_sgn_q   <= b_sgn_c;
        a_scale_q <= a_scale_c;
        b_scale_q <= b_scale_c;
        a_frac_q  <= a_frac_c;
        b_frac_q  <= b_frac_c;
        a_inf_q   <= a_inf_c;
        b_inf_q   <= b_inf_c;
        a_zero_q  <= a_zero_c;
        b_zero_q  <= b_zero_c;
        trunc0_q  <= a_trunc_c | b_trunc_c;
        tag0_q    <= in_tag;
      end
    end
  end

  assign out_valid                        = v_q[LATENCY-1];
  assign {result, out_truncated, out_tag} = pd_q[LATENCY-1];
  assign busy                             = |v_q;

endmodule

// File: tb/tb_posit_raw_mult_pipe_es3.sv
// Directed + random scoreboard bench for posit_raw_mult_pipe_es3, including backpressure and reset.
`timescale 1ns/1ps
module tb_posit_raw_mult_pipe_es3;

  localparam int unsigned SCALE_W = 10;
  localparam int unsigned FRAC_W  = 62;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned TAG_W   = 8;
  localparam int unsigned IN_W    = 1 + SCALE_W + FRAC_W + 2;
  localparam int unsigned PF_W    = 2 * (FRAC_W + 1);
  localparam int unsigned OUT_W   = 1 + (SCALE_W + 1) + PF_W + 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in1, in2;
  logic             in1_truncated, in2_truncated;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] result;
  logic             out_truncated;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  typedef struct packed {
    logic [OUT_W-1:0] r;
    logic             t;
    logic [TAG_W-1:0] g;
  } exp_t;

  exp_t             sb[$];
  exp_t             pop_e;
  int               tests = 0;
  int               fails = 0;
  int               cyc = 0;
  int               n_out = 0;
  int               bp_lo = -1;
  int               bp_hi = -1;
  logic             want_ready = 1'b1;
  bit               stall_seen = 1'b0;
  logic [TAG_W-1:0] tag_ctr = '0;
  logic             held_v = 1'b0;
  logic [OUT_W-1:0] held_r;
  logic [TAG_W-1:0] held_g;

  posit_raw_mult_pipe_es3 #(
    .SCALE_W(SCALE_W), .FRAC_W(FRAC_W), .LATENCY(LATENCY), .TAG_W(TAG_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2),
    .in1_truncated(in1_truncated), .in2_truncated(in2_truncated),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_truncated(out_truncated), .out_tag(out_tag),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [IN_W-1:0] mk_in(input logic s, input logic [SCALE_W-1:0] sc,
                                            input logic [FRAC_W-1:0] f, input logic inf,
                                            input logic z);
    return {s, sc, f, inf, z};
  endfunction

  function automatic logic [OUT_W-1:0] mk_out(input logic s, input logic [SCALE_W:0] sc,
                                              input logic [PF_W-1:0] f, input logic inf,
                                              input logic z);
    return {s, sc, f, inf, z};
  endfunction

  // Reference product for non-zero, non-inf random operands
  function automatic logic [OUT_W-1:0] model(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b);
    logic [PF_W-1:0]  ma, mb, p, fr;
    logic [SCALE_W:0] sc;
    logic             inf, z;
    ma = {{(PF_W-FRAC_W-1){1'b0}}, 1'b1, a[FRAC_W+1:2]};
    mb = {{(PF_W-FRAC_W-1){1'b0}}, 1'b1, b[FRAC_W+1:2]};
    p  = ma * mb;
    sc = {a[IN_W-2], a[IN_W-2 -: SCALE_W]} + {b[IN_W-2], b[IN_W-2 -: SCALE_W]};
    if (p[PF_W-1]) begin
      sc = sc + (SCALE_W+1)'(1);
      fr = p << 1;
    end else begin
      fr = p << 2;
    end
    inf = a[1] | b[1];
    z   = !inf && (a[0] | b[0]);
    return {a[IN_W-1] ^ b[IN_W-1], sc, fr, inf, z};
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] obs, input logic [OUT_W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    out_ready = want_ready && !(cyc >= bp_lo && cyc <= bp_hi);
  endtask

  // Output monitor: scoreboard pop on transfer, stability check while stalled
  always @(negedge clk) begin
    if (!rst_n) begin
      held_v = 1'b0;
    end else if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_output", OUT_W'(1), OUT_W'(0));
      end else begin
        pop_e = sb.pop_front();
        check("result", result, pop_e.r);
        check("truncated", OUT_W'(out_truncated), OUT_W'(pop_e.t));
        check("tag", OUT_W'(out_tag), OUT_W'(pop_e.g));
        n_out++;
      end
      held_v = 1'b0;
    end else if (out_valid) begin
      if (held_v) begin
        check("hold_result", result, held_r);
        check("hold_tag", OUT_W'(out_tag), OUT_W'(held_g));
      end
      held_v = 1'b1;
      held_r = result;
      held_g = out_tag;
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic drive(input logic [IN_W-1:0] a, input logic [IN_W-1:0] b, input logic ta,
                       input logic tb_, input logic [OUT_W-1:0] er, input logic et);
    exp_t x;
    bit   done;
    bit   rdy;
    done = 1'b0;
    in1 = a; in2 = b; in1_truncated = ta; in2_truncated = tb_;
    in_tag = tag_ctr; in_valid = 1'b1;
    x.r = er; x.t = et; x.g = tag_ctr;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      rdy = in_ready;
      if (!rdy) begin
        check("stall_depth", OUT_W'(sb.size()), OUT_W'(LATENCY));
        stall_seen = 1'b1;
      end
      tick();
      if (rdy) begin
        sb.push_back(x);
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
    tag_ctr++;
    if (!done) check("accept_timeout", OUT_W'(0), OUT_W'(1));
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 100 && sb.size() != 0; n++) tick();
    check("drain", OUT_W'(sb.size()), OUT_W'(0));
  endtask

  task automatic latency_probe();
    exp_t x;
    int   lat;
    check("in_ready_idle", OUT_W'(in_ready), OUT_W'(1));
    in1 = mk_in(0, '0, '0, 0, 0); in2 = mk_in(0, '0, '0, 0, 0);
    in1_truncated = 1'b0; in2_truncated = 1'b0;
    in_tag = tag_ctr; in_valid = 1'b1;
    x.r = mk_out(0, '0, '0, 0, 0); x.t = 1'b0; x.g = tag_ctr;
    tick();
    sb.push_back(x);
    in_valid = 1'b0;
    tag_ctr++;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", OUT_W'(lat), OUT_W'(LATENCY));
  endtask

  logic [FRAC_W-1:0] f15;
  logic [PF_W-1:0]   p123, p125;
  logic [IN_W-1:0]   one, ra, rb;
  logic              rta, rtb, zt;
  int                n0;

  initial begin
    f15  = FRAC_W'(1) << 61;
    p123 = PF_W'(1) << 123;
    p125 = PF_W'(1) << 125;
    one  = mk_in(0, '0, '0, 0, 0);
`ifdef POSIT_RAW_MULT_ZERO_CANON_EN
    zt = 1'b0;
`else
    zt = 1'b1;
`endif
    rst_n = 1'b0; in_valid = 1'b0; in1 = '0; in2 = '0;
    in1_truncated = 1'b0; in2_truncated = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("rst_busy", OUT_W'(busy), OUT_W'(0));
    check("rst_result", result, OUT_W'(0));
    check("rst_tag_trunc", OUT_W'({out_tag, out_truncated}), OUT_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", OUT_W'(in_ready), OUT_W'(1));
    tick();

    // 1.0 x 1.0 with latency measurement
    latency_probe();
    wait_drain();

    // Directed products, issued back to back
    drive(mk_in(0, '0, f15, 0, 0), mk_in(1, '0, f15, 0, 0), 0, 0, mk_out(1, 11'd1, p123, 0, 0), 0);
    drive(mk_in(0, 10'd3, '0, 0, 0), mk_in(0, 10'h3FB, '0, 0, 0), 0, 0,
          mk_out(0, 11'h7FE, '0, 0, 0), 0);
    drive(mk_in(0, 10'h1FF, f15, 0, 0), mk_in(0, 10'h1FF, f15, 0, 0), 0, 0,
          mk_out(0, 11'h3FF, p123, 0, 0), 0);
    drive(mk_in(0, 10'h200, '0, 0, 0), mk_in(0, 10'h200, '0, 0, 0), 0, 0,
          mk_out(0, 11'h400, '0, 0, 0), 0);
    drive(mk_in(0, '0, '0, 0, 1), one, 1, 0, mk_out(0, '0, '0, 0, 1), zt);
`ifdef POSIT_RAW_MULT_ZERO_CANON_EN
    drive(mk_in(1, 10'd7, f15, 0, 1), one, 0, 0, mk_out(0, '0, '0, 0, 1), 0);
`else
    drive(mk_in(1, 10'd7, f15, 0, 1), one, 0, 0, mk_out(1, 11'd7, p125, 0, 1), 0);
`endif
    drive(mk_in(0, '0, '0, 1, 0), mk_in(0, '0, '0, 0, 1), 0, 0, mk_out(0, '0, '0, 1, 0), 0);
    wait_drain();

    // Random stream under a backpressure window
    stall_seen = 1'b0;
    n0 = n_out;
    bp_lo = cyc + 3;
    bp_hi = cyc + 9;
    for (int i = 0; i < 10; i++) begin
      ra  = mk_in(1'($urandom), SCALE_W'($urandom), FRAC_W'({$urandom, $urandom}), 0, 0);
      rb  = mk_in(1'($urandom), SCALE_W'($urandom), FRAC_W'({$urandom, $urandom}), 0, 0);
      rta = 1'($urandom);
      rtb = 1'($urandom);
      drive(ra, rb, rta, rtb, model(ra, rb), rta | rtb);
    end
    wait_drain();
    bp_lo = -1;
    bp_hi = -1;
    check("stream_count", OUT_W'(n_out - n0), OUT_W'(10));
    check("stall_seen", OUT_W'(stall_seen), OUT_W'(1));

    // Reset with three items in flight
    want_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(one, one, 0, 0, mk_out(0, '0, '0, 0, 0), 0);
    end
    check("busy_in_flight", OUT_W'(busy), OUT_W'(1));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", OUT_W'(out_valid), OUT_W'(0));
    check("midrst_busy", OUT_W'(busy), OUT_W'(0));
    sb.delete();
    want_ready = 1'b1;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    latency_probe();
    wait_drain();
    check("idle_busy", OUT_W'(busy), OUT_W'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
